// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a {register, data} configuration table and issues one
// I2C driver transaction per entry. Each entry can be read back and compared.
// NACKs and mismatches are retried a bounded number of times. A start
// handshake timeout aborts the sequence.
module i2c_cfg_sequencer #(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned IDX_W       = 4,
  parameter logic [7:0]  DEV_ADDR    = 8'h78,
  parameter int unsigned RETRY_MAX   = 3,
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned START_TO    = 64,
  parameter bit          VERIFY      = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             go,
  output logic [IDX_W-1:0] cfg_addr,
  input  logic [23:0]      cfg_word,
  output logic             drv_start_en,
  output logic             drv_wr_rd_flag,
  output logic [7:0]       drv_device_addr,
  output logic [15:0]      drv_register,
  output logic [7:0]       drv_data_byte,
  input  logic             drv_busy,
  input  logic             drv_err,
  input  logic [7:0]       drv_rd_data,
  output logic             seq_busy,
  output logic             done,
  output logic             fail,
  output logic [IDX_W-1:0] fail_idx,
  output logic [1:0]       fail_code
);

  localparam int unsigned TO_W    = (START_TO > 1) ? $clog2(START_TO) : 1;
  localparam int unsigned GAP_W   = 8;
  localparam int unsigned RETRY_W = 3;

  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(START_TO - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

  localparam logic [15:0] SENTINEL   = 16'hFFFF;
  localparam logic [1:0]  CODE_NACK  = 2'b01;
  localparam logic [1:0]  CODE_MISM  = 2'b10;
  localparam logic [1:0]  CODE_TOUT  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE_WR,
    S_ISSUE_RD,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RETRY,
    S_GAP,
    S_NEXT,
    S_DONE,
    S_FAIL
  } state_t;

  state_t              r_state;
  state_t              r_after;      // where GAP hands over once it expires
  logic [IDX_W-1:0]    r_idx;
  logic [RETRY_W-1:0]  r_retry;
  logic [GAP_W-1:0]    r_gap;
  logic [TO_W-1:0]     r_tmr;
  logic [1:0]          r_code_pend;  // failure cause carried into RETRY
  logic                r_start;
  logic                r_rd;
  logic [7:0]          r_dev;
  logic [15:0]         r_reg;
  logic [7:0]          r_data;
  logic                r_seq_busy;
  logic                r_done;
  logic                r_fail;
  logic [IDX_W-1:0]    r_fail_idx;
  logic [1:0]          r_fail_code;

  // Sequencer state machine; every output is a register updated here.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_after     <= S_IDLE;
      r_idx       <= '0;
      r_retry     <= '0;
      r_gap       <= '0;
      r_tmr       <= '0;
      r_code_pend <= 2'b00;
      r_start     <= 1'b0;
      r_rd        <= 1'b0;
      r_dev       <= DEV_ADDR;
      r_reg       <= 16'h0000;
      r_data      <= 8'h00;
      r_seq_busy  <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_idx  <= '0;
      r_fail_code <= 2'b00;
    end else begin
      r_start <= 1'b0;
      r_dev   <= DEV_ADDR;

      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_idx  <= '0;
            r_fail_code <= 2'b00;
            r_idx       <= '0;
            r_retry     <= '0;
            r_seq_busy  <= 1'b1;
            r_state     <= S_FETCH;
          end
        end

        // cfg_addr already shows r_idx; the ROM answers one cycle later
        S_FETCH: begin
          r_state <= S_LATCH;
        end

        S_LATCH: begin
          r_reg  <= cfg_word[23:8];
          r_data <= cfg_word[7:0];
          if (cfg_word[23:8] == SENTINEL) begin
            r_done     <= 1'b1;
            r_seq_busy <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_state <= S_ISSUE_WR;
          end
        end

        S_ISSUE_WR: begin
          r_start <= 1'b1;
          r_rd    <= 1'b0;
          r_tmr   <= '0;
          r_state <= S_WAIT_BUSY;
        end

        S_ISSUE_RD: begin
          r_start <= 1'b1;
          r_rd    <= 1'b1;
          r_tmr   <= '0;
          r_state <= S_WAIT_BUSY;
        end

        // A driver that never acknowledges the start aborts without retry
        S_WAIT_BUSY: begin
          if (drv_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_tmr == TO_LAST) begin
            r_fail      <= 1'b1;
            r_fail_idx  <= r_idx;
            r_fail_code <= CODE_TOUT;
            r_seq_busy  <= 1'b0;
            r_state     <= S_FAIL;
          end else begin
            r_tmr <= r_tmr + TO_W'(1);
          end
        end

        // Busy was high on entry, so the first low cycle is the falling edge
        S_WAIT_DONE: begin
          if (!drv_busy) begin
            if (drv_err) begin
              r_code_pend <= CODE_NACK;
              r_state     <= S_RETRY;
            end else if (r_rd) begin
              if (drv_rd_data != r_data) begin
                r_code_pend <= CODE_MISM;
                r_state     <= S_RETRY;
              end else begin
                r_gap   <= '0;
                r_after <= S_NEXT;
                r_state <= S_GAP;
              end
            end else begin
              r_gap   <= '0;
              r_after <= VERIFY ? S_ISSUE_RD : S_NEXT;
              r_state <= S_GAP;
            end
          end
        end

        // A failed verify also restarts from the write
        S_RETRY: begin
          if (r_retry < RETRY_LIM) begin
            r_retry <= r_retry + RETRY_W'(1);
            r_gap   <= '0;
            r_after <= S_ISSUE_WR;
            r_state <= S_GAP;
          end else begin
            r_fail      <= 1'b1;
            r_fail_idx  <= r_idx;
            r_fail_code <= r_code_pend;
            r_seq_busy  <= 1'b0;
            r_state     <= S_FAIL;
          end
        end

        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_state <= r_after;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end

        S_NEXT: begin
          r_retry <= '0;
          if (r_idx == LAST_IDX) begin
            r_done     <= 1'b1;
            r_seq_busy <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= S_FETCH;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        S_FAIL: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cfg_addr        = r_idx;
  assign drv_start_en    = r_start;
  assign drv_wr_rd_flag  = r_rd;
  assign drv_device_addr = r_dev;
  assign drv_register    = r_reg;
  assign drv_data_byte   = r_data;
  assign seq_busy        = r_seq_busy;
  assign done            = r_done;
  assign fail            = r_fail;
  assign fail_idx        = r_fail_idx;
  assign fail_code       = r_fail_code;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: two instances share a behavioural I2C driver
// and configuration ROM. Instance A: VERIFY=0, RETRY_MAX=3. Instance B:
// VERIFY=1, RETRY_MAX=0. A reference model derives the expected transaction
// list and final flags.
module tb_i2c_cfg_sequencer;

  localparam int unsigned IW   = 2;
  localparam int unsigned GAP  = 8;
  localparam int unsigned STO  = 20;
  localparam int unsigned LAT  = 1;
  localparam int unsigned BLEN = 4;

  typedef struct packed {
    logic        rw;
    logic [15:0] rg;
    logic [7:0]  dt;
  } tx_t;

  typedef struct packed {
    logic            sel;
    logic [2:0][23:0] tb;
    logic [2:0][2:0] nk;
    logic [2:0]      cr;
    logic            xdone;
    logic            xfail;
    logic [1:0]      xidx;
    logic [1:0]      xcode;
    logic [4:0]      ntx;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go_a = 1'b0;
  logic go_b = 1'b0;
  logic sel = 1'b0;

  logic [IW-1:0] a_addr, b_addr;
  logic [23:0]   a_word = 24'h0, b_word = 24'h0;
  logic          a_start, b_start, a_rw, b_rw;
  logic [7:0]    a_dev, b_dev, a_dat, b_dat;
  logic [15:0]   a_reg, b_reg;
  logic          a_sbusy, b_sbusy, a_done, b_done, a_fail, b_fail;
  logic [IW-1:0] a_fidx, b_fidx;
  logic [1:0]    a_fcode, b_fcode;

  logic          drv_busy = 1'b0;
  logic          drv_err = 1'b0;
  logic [7:0]    drv_rd = 8'h00;

  logic          w_start, w_rw, w_sbusy, w_done, w_fail;
  logic [7:0]    w_dev, w_dat;
  logic [15:0]   w_reg;
  logic [IW-1:0] w_fidx;
  logic [1:0]    w_fcode;

  logic [2:0][23:0] tbl;
  int               nk_cfg[3];
  int               nack_left[3];
  logic [2:0]       corrupt = 3'b000;
  logic             busy_dead = 1'b0;

  int  n_tests = 0;
  int  n_fail = 0;
  int  cyc = 0;
  tx_t got_log[$];
  tx_t exp_log[$];
  logic ex_done, ex_fail;
  int   ex_idx, ex_code;

  int          m_cnt = 0;
  logic        m_nack = 1'b0;
  logic [7:0]  m_rd = 8'h00;
  logic [15:0] m_reg = 16'h0;
  logic        p_busy = 1'b0;
  logic        have_fall = 1'b0;
  int          fall_cyc = 0;

  i2c_cfg_sequencer #(
    .NUM_ENTRIES(3), .IDX_W(IW), .DEV_ADDR(8'h78), .RETRY_MAX(3),
    .GAP_CYCLES(GAP), .START_TO(STO), .VERIFY(1'b0)
  ) dut_a (
    .clk_i(clk), .rst(rst), .go(go_a), .cfg_addr(a_addr), .cfg_word(a_word),
    .drv_start_en(a_start), .drv_wr_rd_flag(a_rw), .drv_device_addr(a_dev),
    .drv_register(a_reg), .drv_data_byte(a_dat), .drv_busy(drv_busy),
    .drv_err(drv_err), .drv_rd_data(drv_rd), .seq_busy(a_sbusy), .done(a_done),
    .fail(a_fail), .fail_idx(a_fidx), .fail_code(a_fcode)
  );

  i2c_cfg_sequencer #(
    .NUM_ENTRIES(3), .IDX_W(IW), .DEV_ADDR(8'h78), .RETRY_MAX(0),
    .GAP_CYCLES(GAP), .START_TO(STO), .VERIFY(1'b1)
  ) dut_b (
    .clk_i(clk), .rst(rst), .go(go_b), .cfg_addr(b_addr), .cfg_word(b_word),
    .drv_start_en(b_start), .drv_wr_rd_flag(b_rw), .drv_device_addr(b_dev),
    .drv_register(b_reg), .drv_data_byte(b_dat), .drv_busy(drv_busy),
    .drv_err(drv_err), .drv_rd_data(drv_rd), .seq_busy(b_sbusy), .done(b_done),
    .fail(b_fail), .fail_idx(b_fidx), .fail_code(b_fcode)
  );

  assign w_start = sel ? b_start : a_start;
  assign w_rw    = sel ? b_rw    : a_rw;
  assign w_dev   = sel ? b_dev   : a_dev;
  assign w_reg   = sel ? b_reg   : a_reg;
  assign w_dat   = sel ? b_dat   : a_dat;
  assign w_sbusy = sel ? b_sbusy : a_sbusy;
  assign w_done  = sel ? b_done  : a_done;
  assign w_fail  = sel ? b_fail  : a_fail;
  assign w_fidx  = sel ? b_fidx  : a_fidx;
  assign w_fcode = sel ? b_fcode : a_fcode;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] rom(input logic [IW-1:0] a);
    if (a < 2'd3) return tbl[a];
    return 24'h0;
  endfunction

  function automatic int ent_of(input logic [15:0] r);
    for (int i = 0; i < 3; i++) if (tbl[i][23:8] == r) return i;
    return 0;
  endfunction

  // Synchronous configuration ROM
  always @(posedge clk) begin
    a_word <= rom(a_addr);
    b_word <= rom(b_addr);
  end

  // Behavioural driver: busy rises LAT cycles after start, lasts BLEN cycles
  always @(posedge clk) begin
    int nxt;
    int e;
    if (w_start && !busy_dead) begin
      e = ent_of(w_reg);
      m_cnt   <= LAT + BLEN;
      drv_err <= 1'b0;
      m_reg   <= w_reg;
      if (nack_left[e] > 0) begin
        nack_left[e] = nack_left[e] - 1;
        m_nack <= 1'b1;
      end else begin
        m_nack <= 1'b0;
      end
      if (w_rw && corrupt[e]) m_rd <= (tbl[e][7:0] == 8'h00) ? 8'hFF : 8'h00;
      else                    m_rd <= tbl[e][7:0];
    end else if (m_cnt != 0) begin
      nxt = m_cnt - 1;
      m_cnt    <= nxt;
      drv_busy <= (nxt != 0) && (nxt <= int'(BLEN));
      if (nxt == 0) begin
        drv_err <= m_nack;
        drv_rd  <= m_rd;
      end
    end
  end

  // Transaction logger plus gap and hold-stability checks
  always @(negedge clk) begin
    if (w_start) begin
      tx_t t;
      t.rw = w_rw;
      t.rg = w_reg;
      t.dt = w_dat;
      if (have_fall) begin
        n_tests++;
        if (!(cyc - fall_cyc > int'(GAP))) begin
          n_fail++;
          $display("FAIL gap: %0d cycles since busy fell, need more than %0d", cyc - fall_cyc, GAP);
        end
      end
      n_tests++;
      if (w_dev !== 8'h78) begin
        n_fail++;
        $display("FAIL dev_addr: got %0h want 78", w_dev);
      end
      got_log.push_back(t);
      have_fall = 1'b0;
    end
    if (p_busy && !drv_busy && w_sbusy) begin
      fall_cyc = cyc;
      have_fall = 1'b1;
      n_tests++;
      if (w_reg !== m_reg) begin
        n_fail++;
        $display("FAIL reg_hold: got %0h want %0h", w_reg, m_reg);
      end
    end
    p_busy = drv_busy;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: expected transaction list and final flags from the table rules
  task automatic ref_run(input logic verify, input int rmax);
    int nl[3];
    int tries;
    int code;
    logic [15:0] rg;
    logic [7:0] dt;
    tx_t t;
    exp_log.delete();
    ex_done = 1'b0; ex_fail = 1'b0; ex_idx = 0; ex_code = 0;
    for (int k = 0; k < 3; k++) nl[k] = nk_cfg[k];
    for (int e = 0; e < 3; e++) begin
      rg = tbl[e][23:8];
      dt = tbl[e][7:0];
      if (rg == 16'hFFFF) begin ex_done = 1'b1; return; end
      tries = 0;
      forever begin
        code = 0;
        t.rw = 1'b0; t.rg = rg; t.dt = dt;
        exp_log.push_back(t);
        if (nl[e] > 0) begin
          nl[e]--; code = 1;
        end else if (verify) begin
          t.rw = 1'b1;
          exp_log.push_back(t);
          if (nl[e] > 0) begin nl[e]--; code = 1; end
          else if (corrupt[e]) code = 2;
        end
        if (code == 0) break;
        if (tries >= rmax) begin
          ex_fail = 1'b1; ex_idx = e; ex_code = code;
          return;
        end
        tries++;
      end
    end
    ex_done = 1'b1;
  endtask

  task automatic start_run(input logic s, input string nm);
    int i;
    sel = s;
    i = 0;
    while (m_cnt != 0 && i < 200) begin @(posedge clk); #1; i++; end
    got_log.delete();
    have_fall = 1'b0;
    for (int k = 0; k < 3; k++) nack_left[k] = nk_cfg[k];
    @(posedge clk); #1;
    if (s) go_b = 1'b1; else go_a = 1'b1;
    @(posedge clk); #1;
    go_a = 1'b0; go_b = 1'b0;
    chk({nm, "_go_busy"}, w_sbusy, 1);
    chk({nm, "_go_clr"}, {w_done, w_fail}, 0);
  endtask

  task automatic wait_end(input string nm);
    int i;
    i = 0;
    while (!(w_done || w_fail) && i < 6000) begin @(posedge clk); #1; i++; end
    if (i >= 6000) begin
      n_tests++; n_fail++;
      $display("FAIL %s_end: no done/fail after %0d cycles", nm, i);
    end
    repeat (5) begin @(posedge clk); #1; end
  endtask

  task automatic check_run(input string nm);
    chk({nm, "_done"}, w_done, ex_done);
    chk({nm, "_fail"}, w_fail, ex_fail);
    chk({nm, "_fidx"}, w_fidx, ex_fail ? ex_idx : 0);
    chk({nm, "_fcode"}, w_fcode, ex_fail ? ex_code : 0);
    chk({nm, "_sbusy"}, w_sbusy, 0);
    chk({nm, "_ntx"}, got_log.size(), exp_log.size());
    for (int k = 0; k < exp_log.size() && k < got_log.size(); k++)
      chk($sformatf("%s_tx%0d", nm, k), got_log[k], exp_log[k]);
  endtask

  task automatic do_run(input logic s, input string nm);
    ref_run(s, s ? 0 : 3);
    start_run(s, nm);
    wait_end(nm);
    check_run(nm);
  endtask

  function automatic vec_t mk(input logic s, input logic [23:0] t0, t1, t2,
                              input int n0, n1, n2, input logic [2:0] cr,
                              input logic xd, xf, input int xi, xc, nt);
    vec_t v;
    v.sel = s;
    v.tb[0] = t0; v.tb[1] = t1; v.tb[2] = t2;
    v.nk[0] = 3'(n0); v.nk[1] = 3'(n1); v.nk[2] = 3'(n2);
    v.cr = cr;
    v.xdone = xd; v.xfail = xf;
    v.xidx = 2'(xi); v.xcode = 2'(xc); v.ntx = 5'(nt);
    return v;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int i;
    int n;
    logic [23:0] T0, T1, T2;
    T0 = 24'h300882; T1 = 24'h310303; T2 = 24'h3017FF;
    vecs[0] = mk(0, T0, T1, T2, 0, 0, 0, 3'b000, 1, 0, 0, 0, 3);
    vecs[1] = mk(1, T0, T1, T2, 0, 0, 0, 3'b000, 1, 0, 0, 0, 6);
    vecs[2] = mk(0, T0, T1, T2, 0, 2, 0, 3'b000, 1, 0, 0, 0, 5);
    vecs[3] = mk(0, T0, T1, T2, 0, 7, 0, 3'b000, 0, 1, 1, 1, 5);
    vecs[4] = mk(1, T0, T1, T2, 0, 0, 0, 3'b001, 0, 1, 0, 2, 2);
    vecs[5] = mk(0, T0, T1, 24'hFFFF00, 0, 0, 0, 3'b000, 1, 0, 0, 0, 2);
    vecs[6] = mk(1, T0, T1, T2, 0, 0, 1, 3'b000, 0, 1, 2, 1, 5);
    vecs[7] = mk(0, T0, T1, T2, 0, 0, 4, 3'b000, 0, 1, 2, 1, 6);
    vecs[8] = mk(1, 24'hFFFF12, T1, T2, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0);

    tbl = {T2, T1, T0};
    for (int k = 0; k < 3; k++) begin nk_cfg[k] = 0; nack_left[k] = 0; end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", a_addr, 0);
    chk("rst_start", a_start, 0);
    chk("rst_rw", a_rw, 0);
    chk("rst_dev", a_dev, 8'h78);
    chk("rst_reg", a_reg, 0);
    chk("rst_dat", a_dat, 0);
    chk("rst_sbusy", a_sbusy, 0);
    chk("rst_flags", {a_done, a_fail, a_fidx, a_fcode}, 0);
    chk("rst_dev_b", b_dev, 8'h78);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Table-driven directed vectors
    for (int v = 0; v < 9; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      tbl = vecs[v].tb;
      corrupt = vecs[v].cr;
      for (int k = 0; k < 3; k++) nk_cfg[k] = int'(vecs[v].nk[k]);
      do_run(vecs[v].sel, nm);
      chk({nm, "_xdone"}, w_done, vecs[v].xdone);
      chk({nm, "_xfail"}, w_fail, vecs[v].xfail);
      if (vecs[v].xfail) begin
        chk({nm, "_xidx"}, w_fidx, vecs[v].xidx);
        chk({nm, "_xcode"}, w_fcode, vecs[v].xcode);
      end
      chk({nm, "_xntx"}, got_log.size(), vecs[v].ntx);
    end

    // Start timeout: driver never raises busy
    tbl = {T2, T1, T0};
    corrupt = 3'b000;
    for (int k = 0; k < 3; k++) nk_cfg[k] = 0;
    busy_dead = 1'b1;
    start_run(0, "tout");
    i = 0;
    while (!w_start && i < 100) begin @(negedge clk); i++; end
    chk("tout_pulse_seen", w_start, 1);
    n = 0;
    while (!w_fail && n < 200) begin @(negedge clk); n++; end
    chk("tout_cycles", n, STO);
    chk("tout_code", w_fcode, 2'b11);
    chk("tout_idx", w_fidx, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("tout_ntx", got_log.size(), 1);
    chk("tout_done", w_done, 0);
    busy_dead = 1'b0;

    // Reset while the driver is busy, then a fresh run with an ignored extra go
    start_run(0, "rstmid");
    i = 0;
    while (!drv_busy && i < 100) begin @(posedge clk); #1; i++; end
    chk("rstmid_busy_seen", drv_busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid_sbusy", a_sbusy, 0);
    chk("rstmid_start", a_start, 0);
    chk("rstmid_flags", {a_done, a_fail}, 0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("rstmid_no_pulse", got_log.size(), 1);
    ref_run(0, 3);
    start_run(0, "rerun");
    repeat (25) @(posedge clk);
    #1;
    chk("rerun_busy_mid", a_sbusy, 1);
    go_a = 1'b1;
    @(posedge clk); #1;
    go_a = 1'b0;
    wait_end("rerun");
    check_run("rerun");

    // Randomized tables and NACK/corruption patterns
    for (int r = 0; r < 24; r++) begin
      logic s;
      s = r[0];
      for (int e = 0; e < 3; e++) begin
        tbl[e] = {8'($urandom), 8'(e), 8'($urandom)};
        if ($urandom_range(0, 7) == 0) tbl[e][23:8] = 16'hFFFF;
        nk_cfg[e] = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
        corrupt[e] = s && ($urandom_range(0, 7) == 0);
      end
      do_run(s, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
